// File: rtl/tube_pkg.sv
// Shared constants for the R3 drain engine: FSM state encoding and default bus widths.
package tube_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_COUNT_W = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_RD0  = 3'd2;
    localparam logic [2:0] S_WR0  = 3'd3;
    localparam logic [2:0] S_RD1  = 3'd4;
    localparam logic [2:0] S_WR1  = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

endpackage

// File: rtl/p_r3_dma_ctr.sv
// Destination address incrementer (wraps at 2**ADDR_W) and remaining-byte decrementer.
// Loads in one cycle; steps once per accepted memory write, never below zero.
module p_r3_dma_ctr
    import tube_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [COUNT_W-1:0] load_count,
    input  logic               step,
    output logic [ADDR_W-1:0]  addr,
    output logic [COUNT_W-1:0] count,
    output logic               zero,
    output logic               last
);

    assign zero = (count == '0);
    assign last = (count == COUNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            count <= '0;
        end else if (load) begin
            addr  <= load_addr;
            count <= load_count;
        end else if (step && !zero) begin
            addr  <= addr + 1'b1;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/p_r3_dma.sv
// Drains the host->parasite R3 FIFO into parasite memory, one or two bytes per FIFO grant;
// read strobe follows data-available by one cycle, writes hold until mem_ready. Option: P_R3_DMA_IRQ_EN.
module p_r3_dma
    import tube_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               p_phi2,
    input  logic               p_rst_b,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [COUNT_W-1:0] byte_count,
    input  logic               one_byte_mode,
    input  logic               p_data_available,
    input  logic               p_two_bytes_available,
    input  logic [7:0]         p_data,
    output logic               p_selectData,
    output logic               p_rdnw,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic               busy,
    output logic               done,
    output logic               aborted
`ifdef P_R3_DMA_IRQ_EN
    ,
    output logic               irq,
    input  logic               irq_ack
`endif
);

    logic [2:0]         state;
    logic [2:0]         next_state;
    logic               pair_mode;
    logic               rd_go;
    logic               accept;
    logic               ctr_load;
    logic               cnt_zero;
    logic               cnt_last;
    logic [COUNT_W-1:0] cnt_unused;

    assign accept   = mem_we & mem_ready;
    assign ctr_load = (state == S_IDLE) & start & ~abort;

    // The tail of an odd two-byte transfer only needs its first byte, so a lone byte suffices.
    assign rd_go = one_byte_mode ? p_data_available
                                 : (p_two_bytes_available | (cnt_last & p_data_available));

    p_r3_dma_ctr #(
        .ADDR_W  (ADDR_W),
        .COUNT_W (COUNT_W)
    ) u_ctr (
        .clk        (p_phi2),
        .rst_n      (p_rst_b),
        .load       (ctr_load),
        .load_addr  (start_addr),
        .load_count (byte_count),
        .step       (accept),
        .addr       (mem_addr),
        .count      (cnt_unused),
        .zero       (cnt_zero),
        .last       (cnt_last)
    );

    always_ff @(posedge p_phi2 or negedge p_rst_b) begin
        if (!p_rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (byte_count == '0) ? S_FIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    next_state = S_FIN;
                end else if (rd_go) begin
                    next_state = S_RD0;
                end
            end
            S_RD0: next_state = S_WR0;
            S_RD1: next_state = S_WR1;
            S_WR0: begin
                if (accept) begin
                    if (cnt_last) begin
                        next_state = S_FIN;
                    end else begin
                        next_state = pair_mode ? S_RD1 : S_WAIT;
                    end
                end
            end
            S_WR1: begin
                if (accept) begin
                    next_state = cnt_last ? S_FIN : S_WAIT;
                end
            end
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (abort) begin
            next_state = S_IDLE;
        end
    end

    always_comb begin
        p_selectData = 1'b0;
        p_rdnw       = 1'b1;
        mem_we       = 1'b0;
        done         = 1'b0;
        busy         = (state != S_IDLE);
        case (state)
            S_RD0, S_RD1: p_selectData = 1'b1;
            S_WR0, S_WR1: mem_we       = 1'b1;
            S_FIN:        done         = 1'b1;
            default:      ;
        endcase
    end

    // Mode is latched on the grant so a mid-pair flag change waits for the next WAIT.
    always_ff @(posedge p_phi2 or negedge p_rst_b) begin
        if (!p_rst_b) begin
            mem_wdata <= '0;
            pair_mode <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            if (p_selectData) begin
                mem_wdata <= p_data;
            end
            if ((state == S_WAIT) && rd_go) begin
                pair_mode <= ~one_byte_mode;
            end
            if (abort) begin
                aborted <= 1'b1;
            end else if ((state == S_IDLE) && start) begin
                aborted <= 1'b0;
            end
        end
    end

`ifdef P_R3_DMA_IRQ_EN
    always_ff @(posedge p_phi2 or negedge p_rst_b) begin
        if (!p_rst_b) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_p_r3_dma.sv
// Self-checking bench: queue model of the R3 FIFO and of the expected destination writes.
module tb_p_r3_dma;

    logic        p_phi2;
    logic        p_rst_b;
    logic        start;
    logic        abort;
    logic [15:0] start_addr;
    logic [15:0] byte_count;
    logic        one_byte_mode;
    logic        p_data_available;
    logic        p_two_bytes_available;
    logic [7:0]  p_data;
    logic        p_selectData;
    logic        p_rdnw;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        aborted;
`ifdef P_R3_DMA_IRQ_EN
    logic        irq;
    logic        irq_ack;
`endif

    p_r3_dma dut (
        .p_phi2                (p_phi2),
        .p_rst_b               (p_rst_b),
        .start                 (start),
        .abort                 (abort),
        .start_addr            (start_addr),
        .byte_count            (byte_count),
        .one_byte_mode         (one_byte_mode),
        .p_data_available      (p_data_available),
        .p_two_bytes_available (p_two_bytes_available),
        .p_data                (p_data),
        .p_selectData          (p_selectData),
        .p_rdnw                (p_rdnw),
        .mem_addr              (mem_addr),
        .mem_wdata             (mem_wdata),
        .mem_we                (mem_we),
        .mem_ready             (mem_ready),
        .busy                  (busy),
        .done                  (done),
        .aborted               (aborted)
`ifdef P_R3_DMA_IRQ_EN
        ,
        .irq                   (irq),
        .irq_ack               (irq_ack)
`endif
    );

    initial p_phi2 = 1'b0;
    always #5 p_phi2 = ~p_phi2;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fifo[$];
    logic [7:0]  src[$];
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    int          rdy_mode = 0;
    int          feed_pct = 100;
    int          we_run = 0;
    bit          we_hold = 0;
    logic [15:0] hold_addr;
    logic [7:0]  hold_wd;
    int          writes_seen = 0;
    int          done_seen = 0;
    int          sel_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        p_data                = (fifo.size() > 0) ? fifo[0] : 8'h00;
        p_data_available      = (fifo.size() >= 1);
        p_two_bytes_available = (fifo.size() >= 2);
    endtask

    // One clock: sample at negedge, apply FIFO/memory effects of the edge, drive next inputs.
    task automatic step();
        logic        s_sel, s_we, s_rdy;
        logic [15:0] s_addr;
        logic [7:0]  s_wd, b;
        @(negedge p_phi2);
        s_sel  = p_selectData;
        s_we   = mem_we;
        s_rdy  = mem_ready;
        s_addr = mem_addr;
        s_wd   = mem_wdata;
        if (s_sel) begin
            chk("rdnw_during_read", p_rdnw, 1);
            chk("read_while_we", s_we, 0);
            chk("read_from_empty_fifo", fifo.size() > 0, 1);
        end
        if (s_we && we_hold) begin
            chk("held_addr_stable", s_addr, hold_addr);
            chk("held_wdata_stable", s_wd, hold_wd);
        end
        if (done) done_seen++;
        @(posedge p_phi2);
        #1;
        start = 1'b0;
        abort = 1'b0;
`ifdef P_R3_DMA_IRQ_EN
        irq_ack = 1'b0;
`endif
        if (s_sel && fifo.size() > 0) begin
            b = fifo.pop_front();
            sel_seen++;
            chk("capture_wdata", mem_wdata, b);
        end
        if (s_we && s_rdy) begin
            writes_seen++;
            chk("write_expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) begin
                chk("write_addr", s_addr, exp_addr.pop_front());
                chk("write_data", s_wd, exp_data.pop_front());
            end
            we_hold = 0;
            we_run  = 0;
        end else if (s_we) begin
            we_hold   = 1;
            hold_addr = s_addr;
            hold_wd   = s_wd;
            we_run++;
        end else begin
            we_hold = 0;
            we_run  = 0;
        end
        if (src.size() > 0 && $urandom_range(99) < feed_pct) fifo.push_back(src.pop_front());
        drive_fifo();
        case (rdy_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = 1'($urandom_range(1));
            default: mem_ready = (we_run >= 5);
        endcase
    endtask

    // Runs a whole transfer of the first n bytes of src; leftover bytes must stay unread.
    task automatic xfer(input string tag, input logic [15:0] a, input int n, input logic mode,
                        input int extra, input bit pre, input bit poke, output int lat);
        lat = 0;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(a + 16'(i));
            exp_data.push_back(src[i]);
        end
        if (pre) while (src.size() > 0) fifo.push_back(src.pop_front());
        drive_fifo();
        one_byte_mode = mode;
        start_addr    = a;
        byte_count    = 16'(n);
        start         = 1'b1;
        done_seen     = 0;
        sel_seen      = 0;
        writes_seen   = 0;
        step();
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_aborted_cleared"}, aborted, 0);
        while (done_seen == 0 && lat < 4000) begin
            if (poke && lat == 2) begin
                start      = 1'b1;
                start_addr = ~a;
                byte_count = 16'd7;
            end
            step();
            lat++;
        end
        repeat (3) step();
        chk({tag, "_done_once"}, done_seen, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_writes"}, writes_seen, n);
        chk({tag, "_reads"}, sel_seen, n);
        chk({tag, "_all_written"}, exp_addr.size(), 0);
        chk({tag, "_leftover"}, fifo.size() + src.size(), extra);
        fifo.delete();
        src.delete();
        exp_addr.delete();
        exp_data.delete();
        drive_fifo();
    endtask

    initial begin
        int lat, n;
        logic [15:0] a;
        logic        m;
        int          ex;
        p_rst_b    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        start_addr = '0;
        byte_count = '0;
        one_byte_mode = 1'b1;
        mem_ready  = 1'b0;
`ifdef P_R3_DMA_IRQ_EN
        irq_ack = 1'b0;
`endif
        drive_fifo();
        repeat (2) @(negedge p_phi2);
        chk("rst_sel", p_selectData, 0);
        chk("rst_rdnw", p_rdnw, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
`ifdef P_R3_DMA_IRQ_EN
        chk("rst_irq", irq, 0);
`endif
        p_rst_b = 1'b1;
        step();

        // one-byte mode, three bytes, always ready
        rdy_mode = 0;
        src = '{8'hA5, 8'h5A, 8'hC3};
        xfer("t1", 16'h0800, 3, 1'b1, 0, 1, 0, lat);
        chk("t1_latency", lat, 10);

        // two-byte mode: RD0,WR0,RD1,WR1 back to back per pair
        src = '{8'h11, 8'h22, 8'h33, 8'h44};
        xfer("t2", 16'h2000, 4, 1'b0, 0, 1, 0, lat);
        chk("t2_latency", lat, 11);

        // memory stalls 5 cycles on every write
        rdy_mode = 2;
        src = '{8'h9C, 8'h3E};
        xfer("t3", 16'h4000, 2, 1'b1, 0, 1, 0, lat);
        chk("t3_latency", lat, 17);

        // address wrap
        rdy_mode = 0;
        src = '{8'h77, 8'h88};
        xfer("t4", 16'hFFFF, 2, 1'b0, 0, 1, 0, lat);

        // abort while WR1 is stalled
        rdy_mode = 2;
        src = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        while (src.size() > 0) fifo.push_back(src.pop_front());
        drive_fifo();
        exp_addr.push_back(16'h1234);
        exp_data.push_back(8'hDE);
        one_byte_mode = 1'b0;
        start_addr = 16'h1234;
        byte_count = 16'd4;
        start = 1'b1;
        done_seen = 0; sel_seen = 0; writes_seen = 0;
        step();
        n = 0;
        while (!(writes_seen == 1 && mem_we) && n < 100) begin
            step();
            n++;
        end
        chk("t5_in_wr1", writes_seen == 1 && mem_we, 1);
        chk("t5_stalled", mem_ready, 0);
        abort = 1'b1;
        step();
        chk("t5_busy", busy, 0);
        chk("t5_aborted", aborted, 1);
        chk("t5_we_dropped", mem_we, 0);
        repeat (10) step();
        chk("t5_reads", sel_seen, 2);
        chk("t5_writes", writes_seen, 1);
        chk("t5_no_done", done_seen, 0);
        chk("t5_fifo_left", fifo.size(), 2);
        chk("t5_aborted_sticky", aborted, 1);
        fifo.delete();
        exp_addr.delete();
        exp_data.delete();
        rdy_mode = 0;

        // zero count restarts after abort; a queued byte must not be read
        src = '{8'h5F};
        xfer("t6", 16'h0100, 0, 1'b1, 1, 1, 0, lat);
        chk("t6_latency_bound", lat <= 2, 1);
`ifdef P_R3_DMA_IRQ_EN
        chk("t6_irq_set", irq, 1);
        repeat (2) step();
        chk("t6_irq_held", irq, 1);
        irq_ack = 1'b1;
        step();
        chk("t6_irq_cleared", irq, 0);
`endif

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        byte_count = 16'd3;
        step();
        chk("sa_busy", busy, 0);
        chk("sa_aborted", aborted, 1);
        repeat (2) step();
        chk("sa_still_idle", busy, 0);

        // randomized transfers; stray start pulses mid-transfer must be ignored
        for (int t = 0; t < 12; t++) begin
            m  = 1'($urandom_range(1));
            n  = $urandom_range(12, 1);
            a  = ($urandom_range(3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(7))) : 16'($urandom);
            ex = (!m && (n % 2 == 1)) ? 1 : 0;
            rdy_mode = $urandom_range(1);
            feed_pct = $urandom_range(100, 30);
            for (int i = 0; i < n + ex; i++) src.push_back(8'($urandom));
            xfer("rnd", a, n, m, ex, 0, n >= 4, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
